alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 128 ++++++++++++
 tb/tb_alu_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU.
// A single operation is in flight: accept (IDLE) -> drive ALU (EXEC) -> hold result (RESP).
module alu_arbiter #(
  parameter int OP_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  input  logic            req1_valid,
  output logic            req0_ready,
  output logic            req1_ready,
  input  logic [31:0]     req0_a,
  input  logic [31:0]     req0_b,
  input  logic [31:0]     req1_a,
  input  logic [31:0]     req1_b,
  input  logic [OP_W-1:0] req0_op,
  input  logic [OP_W-1:0] req1_op,
  input  logic            req0_ovj,
  input  logic            req1_ovj,
  output logic            resp0_valid,
  output logic            resp1_valid,
  input  logic            resp0_ready,
  input  logic            resp1_ready,
  output logic [31:0]     resp_out,
  output logic            resp_over,
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  output logic [OP_W-1:0] alu_op,
  output logic            alu_ovj,
  input  logic [31:0]     alu_out,
  input  logic            alu_over
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state_q, state_d;
  logic            prio_q, prio_d;
  logic            owner_q, owner_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            ovj_q, ovj_d;
  logic [31:0]     resp_out_q, resp_out_d;
  logic            resp_over_q, resp_over_d;
  logic            grant;

  // grant = 1 selects requester 1: either it is the only one asking, or prio favours it
  assign grant = req1_valid && (!req0_valid || prio_q);

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    ovj_d       = ovj_q;
    resp_out_d  = resp_out_q;
    resp_over_d = resp_over_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = '0;
    alu_ovj     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // ready is gated by rst_n so it drops the instant reset asserts
        req0_ready = rst_n && req0_valid && !grant;
        req1_ready = rst_n && req1_valid && grant;
        if (req0_valid || req1_valid) begin
          a_d     = grant ? req1_a   : req0_a;
          b_d     = grant ? req1_b   : req0_b;
          op_d    = grant ? req1_op  : req0_op;
          ovj_d   = grant ? req1_ovj : req0_ovj;
          owner_d = grant;
          prio_d  = !grant;
          state_d = EXEC;
        end
      end
      EXEC: begin
        alu_a       = a_q;
        alu_b       = b_q;
        alu_op      = op_q;
        alu_ovj     = ovj_q;
        resp_out_d  = alu_out;
        resp_over_d = alu_over;
        state_d     = RESP;
      end
      RESP: begin
        resp0_valid = !owner_q;
        resp1_valid = owner_q;
        if (owner_q ? resp1_ready : resp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      owner_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      ovj_q       <= 1'b0;
      resp_out_q  <= '0;
      resp_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      owner_q     <= owner_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      ovj_q       <= ovj_d;
      resp_out_q  <= resp_out_d;
      resp_over_q <= resp_over_d;
    end
  end

  assign resp_out  = resp_out_q;
  assign resp_over = resp_over_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small ALU model (0 add, 1 sub, 2 and, 3 or).
module tb_alu_arbiter;

  localparam int OP_W = 4;
  localparam logic [OP_W-1:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0]     req0_a, req0_b, req1_a, req1_b;
  logic [OP_W-1:0] req0_op, req1_op;
  logic            req0_ovj, req1_ovj;
  logic            resp0_valid, resp1_valid, resp0_ready, resp1_ready;
  logic [31:0]     resp_out;
  logic            resp_over;
  logic [31:0]     alu_a, alu_b, alu_out;
  logic [OP_W-1:0] alu_op;
  logic            alu_ovj, alu_over;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.OP_W(OP_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_ovj(req0_ovj), .req1_ovj(req1_ovj),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp0_ready(resp0_ready), .resp1_ready(resp1_ready),
    .resp_out(resp_out), .resp_over(resp_over),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_ovj(alu_ovj),
    .alu_out(alu_out), .alu_over(alu_over)
  );

  // Bench ALU: signed overflow flagged only when alu_ovj is set
  always_comb begin
    alu_out  = '0;
    alu_over = 1'b0;
    case (alu_op)
      4'd0: begin
        alu_out  = alu_a + alu_b;
        alu_over = alu_ovj && (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      4'd1: begin
        alu_out  = alu_a - alu_b;
        alu_over = alu_ovj && (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      4'd2: alu_out = alu_a & alu_b;
      4'd3: alu_out = alu_a | alu_b;
      default: alu_out = '0;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic sel, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [OP_W-1:0] op, input logic ovj);
    if (sel) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op; req1_ovj = ovj;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op; req0_ovj = ovj;
    end
  endtask

  // Issue one operation from an idle arbiter and consume its response at once
  task automatic run_op(input logic sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [OP_W-1:0] op, input logic ovj,
                        input logic [31:0] eout, input logic eover);
    @(negedge clk);
    set_req(sel, 1'b1, a, b, op, ovj);
    #1;
    chk("ready_own", {31'd0, sel ? req1_ready : req0_ready}, 32'd1);
    chk("ready_other", {31'd0, sel ? req0_ready : req1_ready}, 32'd0);
    @(negedge clk);
    set_req(sel, 1'b0, '0, '0, '0, 1'b0);
    #1;
    chk("exec_alu_a", alu_a, a);
    chk("exec_alu_b", alu_b, b);
    chk("exec_alu_op", {28'd0, alu_op}, {28'd0, op});
    chk("exec_alu_ovj", {31'd0, alu_ovj}, {31'd0, ovj});
    @(negedge clk);
    #1;
    chk("resp_valid_own", {31'd0, sel ? resp1_valid : resp0_valid}, 32'd1);
    chk("resp_valid_other", {31'd0, sel ? resp0_valid : resp1_valid}, 32'd0);
    chk("resp_out", resp_out, eout);
    chk("resp_over", {31'd0, resp_over}, {31'd0, eover});
    if (sel) resp1_ready = 1'b1; else resp0_ready = 1'b1;
    @(negedge clk);
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    #1;
    chk("idle_resp_valid", {30'd0, resp0_valid, resp1_valid}, 32'd0);
    chk("idle_resp_out_held", resp_out, eout);
    chk("idle_alu_a_zero", alu_a, 32'd0);
  endtask

  typedef struct {
    logic            sel;
    logic [31:0]     a;
    logic [31:0]     b;
    logic [OP_W-1:0] op;
    logic            ovj;
    logic [31:0]     eout;
    logic            eover;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b0, 32'd5, 32'd3, OP_ADD, 1'b0, 32'd8, 1'b0};
    vecs[1] = '{1'b1, 32'h7FFFFFFF, 32'd1, OP_ADD, 1'b1, 32'h80000000, 1'b1};
    vecs[2] = '{1'b1, 32'h7FFFFFFF, 32'd1, OP_ADD, 1'b0, 32'h80000000, 1'b0};
    vecs[3] = '{1'b0, 32'd9, 32'd4, OP_SUB, 1'b0, 32'd5, 1'b0};
    vecs[4] = '{1'b0, 32'h80000000, 32'd1, OP_SUB, 1'b1, 32'h7FFFFFFF, 1'b1};
    vecs[5] = '{1'b1, 32'h000000F0, 32'h0000003C, OP_AND, 1'b0, 32'h00000030, 1'b0};

    rst_n = 1'b0;
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    set_req(1'b0, 1'b0, '0, '0, '0, 1'b0);
    set_req(1'b1, 1'b0, '0, '0, '0, 1'b0);
    #1;
    chk("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    chk("rst_resp_valid", {30'd0, resp0_valid, resp1_valid}, 32'd0);
    chk("rst_resp_out", resp_out, 32'd0);
    chk("rst_alu", {alu_a[27:0], alu_op}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Contention right after reset: requester 0 wins, then requester 1
    @(negedge clk);
    set_req(1'b0, 1'b1, 32'd1, 32'd1, OP_ADD, 1'b0);
    set_req(1'b1, 1'b1, 32'd9, 32'd4, OP_SUB, 1'b0);
    #1;
    chk("cont_ready0", {31'd0, req0_ready}, 32'd1);
    chk("cont_ready1", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk("cont_busy_ready1", {31'd0, req1_ready}, 32'd0);
    chk("cont_exec_a", alu_a, 32'd1);
    @(negedge clk);
    #1;
    chk("cont_resp0_valid", {31'd0, resp0_valid}, 32'd1);
    chk("cont_resp0_out", resp_out, 32'd2);
    resp0_ready = 1'b1;
    @(negedge clk);
    resp0_ready = 1'b0;
    #1;
    chk("cont_ready1_after", {31'd0, req1_ready}, 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    chk("cont_exec_a1", alu_a, 32'd9);
    @(negedge clk);
    #1;
    chk("cont_resp1_valid", {31'd0, resp1_valid}, 32'd1);
    chk("cont_resp1_out", resp_out, 32'd5);
    resp1_ready = 1'b1;
    @(negedge clk);
    resp1_ready = 1'b0;
    set_req(1'b0, 1'b1, 32'd1, 32'd1, OP_ADD, 1'b0);
    set_req(1'b1, 1'b1, 32'd2, 32'd2, OP_ADD, 1'b0);
    #1;
    chk("prio_back_ready0", {31'd0, req0_ready}, 32'd1);
    chk("prio_back_ready1", {31'd0, req1_ready}, 32'd0);
    // Both withdraw before the edge: no accept may happen
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("withdraw_no_exec", alu_a, 32'd0);
    @(negedge clk);
    #1;
    chk("withdraw_no_resp", {30'd0, resp0_valid, resp1_valid}, 32'd0);

    for (int unsigned i = 0; i < 6; i++)
      run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].ovj, vecs[i].eout, vecs[i].eover);

    // Cancel: req0_valid pulsed before the grant edge
    @(negedge clk);
    set_req(1'b0, 1'b1, 32'd77, 32'd1, OP_ADD, 1'b0);
    #1;
    chk("cancel_ready_on", {31'd0, req0_ready}, 32'd1);
    #2;
    req0_valid = 1'b0;
    #1;
    chk("cancel_ready_off", {31'd0, req0_ready}, 32'd0);
    @(negedge clk);
    #1;
    chk("cancel_no_exec", alu_a, 32'd0);
    @(negedge clk);
    #1;
    chk("cancel_no_resp", {31'd0, resp0_valid}, 32'd0);

    // Backpressure on resp0 with req1 waiting and a stray resp1_ready
    run_op(1'b0, 32'd2, 32'd3, OP_ADD, 1'b0, 32'd5, 1'b0);
    @(negedge clk);
    set_req(1'b0, 1'b1, 32'd2, 32'd3, OP_ADD, 1'b0);
    @(negedge clk);
    req0_valid = 1'b0;
    set_req(1'b1, 1'b1, 32'd10, 32'd20, OP_ADD, 1'b0);
    @(negedge clk);
    resp1_ready = 1'b1;
    for (int unsigned k = 0; k < 5; k++) begin
      #1;
      chk("bp_resp0_valid", {31'd0, resp0_valid}, 32'd1);
      chk("bp_resp_out", resp_out, 32'd5);
      chk("bp_req1_ready", {31'd0, req1_ready}, 32'd0);
      @(negedge clk);
    end
    resp1_ready = 1'b0;
    resp0_ready = 1'b1;
    @(negedge clk);
    resp0_ready = 1'b0;
    #1;
    chk("bp_req1_accept", {31'd0, req1_ready}, 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    chk("bp_exec_a", alu_a, 32'd10);
    @(negedge clk);
    #1;
    chk("bp_resp1_out", resp_out, 32'd30);
    chk("bp_resp1_valid", {31'd0, resp1_valid}, 32'd1);
    resp1_ready = 1'b1;
    @(negedge clk);
    resp1_ready = 1'b0;

    // Reset asserted during EXEC aborts the operation
    set_req(1'b1, 1'b1, 32'd4, 32'd4, OP_ADD, 1'b1);
    @(negedge clk);
    req1_valid = 1'b0;
    req0_valid = 1'b1;
    #1;
    chk("rstx_exec_a", alu_a, 32'd4);
    rst_n = 1'b0;
    #1;
    chk("rstx_alu_a", alu_a, 32'd0);
    chk("rstx_alu_ctl", {30'd0, alu_ovj, |alu_op}, 32'd0);
    chk("rstx_resp_out", resp_out, 32'd0);
    chk("rstx_ready0", {31'd0, req0_ready}, 32'd0);
    req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("rstx_no_resp", {30'd0, resp0_valid, resp1_valid}, 32'd0);
    end
    run_op(1'b1, 32'd6, 32'd7, OP_ADD, 1'b0, 32'd13, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
